// File: rtl/fir_coeff_loader.sv
// Coefficient loader: a host fills a local buffer, then a Start pulse streams it to one
// FIR_FUN instance over the isConfig / isConfigACK / isConfigDone handshake, with timeout.
module fir_coeff_loader #(
   parameter int COEFF_WIDTH      = 24,
   parameter int FILTER_MAX_ORDER = 256,
   parameter int ADDR_WIDTH       = 10,
   parameter int TIMEOUT_CYCLES   = 1023
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_host_wr_en,
   input  logic [ADDR_WIDTH-1:0]  i_host_wr_addr,
   input  logic [COEFF_WIDTH-1:0] i_host_wr_data,
   input  logic                   i_start,
   output logic                   o_is_config,
   input  logic                   i_is_config_ack,
   input  logic                   i_is_config_done,
   output logic [COEFF_WIDTH-1:0] o_data_config_out,
   output logic                   o_busy,
   output logic                   o_load_done,
   output logic                   o_load_error,
   output logic                   o_wr_reject
);

   localparam int NUM_COEFF = FILTER_MAX_ORDER + 2;
   localparam int MEM_AW    = $clog2(NUM_COEFF);
   localparam int IDX_W     = $clog2(NUM_COEFF + 1);
   localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [ADDR_WIDTH:0] LP_NUM_ADDR = (ADDR_WIDTH + 1)'(NUM_COEFF);
   localparam logic [IDX_W-1:0]    LP_IDX_LAST = IDX_W'(NUM_COEFF - 1);
   localparam logic [IDX_W-1:0]    LP_IDX_ONE  = IDX_W'(1);
   localparam logic [TMR_W-1:0]    LP_TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_STREAM,
      S_WAIT_DONE
   } state_t;

   typedef enum logic [1:0] {
      D_HOLD,
      D_LOAD,
      D_ZERO
   } data_op_t;

   logic [COEFF_WIDTH-1:0] r_mem [0:NUM_COEFF-1];

   state_t                 r_state;
   state_t                 w_state_next;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_next;
   logic [TMR_W-1:0]       r_timer;
   logic [TMR_W-1:0]       w_timer_next;
   logic                   r_is_config;
   logic                   w_is_config_next;
   logic                   r_busy;
   logic                   w_busy_next;
   logic                   r_load_done;
   logic                   w_load_done_next;
   logic                   r_load_error;
   logic                   w_load_error_next;
   logic                   r_wr_reject;
   logic                   w_wr_reject_next;
   logic [COEFF_WIDTH-1:0] r_data;
   data_op_t               w_data_op;
   logic                   w_addr_ok;
   logic                   w_wr_accept;
   logic [MEM_AW-1:0]      w_wr_idx;
   logic [MEM_AW-1:0]      w_rd_idx;

   assign w_addr_ok        = ({1'b0, i_host_wr_addr} < LP_NUM_ADDR);
   assign w_wr_accept      = i_host_wr_en && (r_state == S_IDLE) && w_addr_ok;
   assign w_wr_reject_next = i_host_wr_en && !w_wr_accept;
   assign w_wr_idx         = i_host_wr_addr[MEM_AW-1:0];
   // The bus always carries the word addressed by the idx value being loaded this edge.
   assign w_rd_idx         = w_idx_next[MEM_AW-1:0];

   always_ff @(posedge i_clk) begin
      if (w_wr_accept) begin
         r_mem[w_wr_idx] <= i_host_wr_data;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_idx_next        = r_idx;
      w_timer_next      = r_timer;
      w_is_config_next  = r_is_config;
      w_busy_next       = r_busy;
      w_load_done_next  = 1'b0;
      w_load_error_next = 1'b0;
      w_data_op         = D_HOLD;

      case (r_state)
         S_IDLE: begin
            w_idx_next   = '0;
            w_timer_next = '0;
            if (i_start) begin
               // A FIR_FUN already acknowledging cannot be safely requested again.
               if (i_is_config_ack) begin
                  w_load_error_next = 1'b1;
               end else begin
                  w_state_next     = S_REQ;
                  w_is_config_next = 1'b1;
                  w_busy_next      = 1'b1;
                  w_data_op        = D_LOAD;
               end
            end
         end

         S_REQ: begin
            w_timer_next = r_timer + 1'b1;
            if (i_is_config_ack) begin
               w_state_next     = S_STREAM;
               w_is_config_next = 1'b0;
               w_idx_next       = LP_IDX_ONE;
               w_data_op        = D_LOAD;
            end else if (r_timer == LP_TMO_LAST) begin
               w_state_next      = S_IDLE;
               w_is_config_next  = 1'b0;
               w_busy_next       = 1'b0;
               w_load_error_next = 1'b1;
               w_idx_next        = '0;
               w_data_op         = D_ZERO;
            end
         end

         S_STREAM: begin
            if (i_is_config_ack) begin
               w_idx_next = r_idx + 1'b1;
               if (r_idx == LP_IDX_LAST) begin
                  w_state_next = S_WAIT_DONE;
                  w_timer_next = '0;
                  w_data_op    = D_ZERO;
               end else begin
                  w_data_op = D_LOAD;
               end
            end else begin
               // ACK dropped before the last word was taken.
               w_state_next      = S_IDLE;
               w_busy_next       = 1'b0;
               w_load_error_next = 1'b1;
               w_idx_next        = '0;
               w_data_op         = D_ZERO;
            end
         end

         S_WAIT_DONE: begin
            w_timer_next = r_timer + 1'b1;
            if (i_is_config_done) begin
               w_state_next     = S_IDLE;
               w_busy_next      = 1'b0;
               w_load_done_next = 1'b1;
               w_idx_next       = '0;
            end else if (r_timer == LP_TMO_LAST) begin
               w_state_next      = S_IDLE;
               w_is_config_next  = 1'b0;
               w_busy_next       = 1'b0;
               w_load_error_next = 1'b1;
               w_idx_next        = '0;
               w_data_op         = D_ZERO;
            end
         end

         default: begin
            w_state_next     = S_IDLE;
            w_is_config_next = 1'b0;
            w_busy_next      = 1'b0;
            w_idx_next       = '0;
            w_timer_next     = '0;
            w_data_op        = D_ZERO;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_timer      <= '0;
         r_is_config  <= 1'b0;
         r_busy       <= 1'b0;
         r_load_done  <= 1'b0;
         r_load_error <= 1'b0;
         r_wr_reject  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_idx        <= w_idx_next;
         r_timer      <= w_timer_next;
         r_is_config  <= w_is_config_next;
         r_busy       <= w_busy_next;
         r_load_done  <= w_load_done_next;
         r_load_error <= w_load_error_next;
         r_wr_reject  <= w_wr_reject_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data <= '0;
      end else begin
         case (w_data_op)
            D_LOAD:  r_data <= r_mem[w_rd_idx];
            D_ZERO:  r_data <= '0;
            default: r_data <= r_data;
         endcase
      end
   end

   assign o_is_config       = r_is_config;
   assign o_data_config_out = r_data;
   assign o_busy            = r_busy;
   assign o_load_done       = r_load_done;
   assign o_load_error      = r_load_error;
   assign o_wr_reject       = r_wr_reject;

endmodule
